// File: rtl/gaussian_pkg.sv
// gaussian_pkg: accelerator register map, sequencer states and per-window timing
// shared by the Gaussian window sequencer and its address generator.
package gaussian_pkg;
  localparam logic [3:0] ACC_RESULT = 4'd0;
  localparam logic [3:0] ACC_IMG00  = 4'd1;
  localparam logic [3:0] ACC_IMG01  = 4'd2;
  localparam logic [3:0] ACC_IMG02  = 4'd3;
  localparam logic [3:0] ACC_IMG10  = 4'd4;
  localparam logic [3:0] ACC_IMG11  = 4'd5;
  localparam logic [3:0] ACC_IMG12  = 4'd6;
  localparam logic [3:0] ACC_IMG20  = 4'd7;
  localparam logic [3:0] ACC_IMG21  = 4'd8;
  localparam logic [3:0] ACC_IMG22  = 4'd9;
  localparam logic [3:0] FETCH_LEN  = 4'd10;
  localparam int         PIX_CYCLES = 12;
  typedef enum logic [2:0] {IDLE, CHECK, FETCH, CONV, STORE, DONE} state_t;
  function automatic logic [1:0] win_row(input logic [3:0] k);
    return k < 4'd3 ? 2'd0 : k < 4'd6 ? 2'd1 : 2'd2;
  endfunction
  function automatic logic [1:0] win_col(input logic [3:0] k);
    return k < 4'd3 ? k[1:0] : k < 4'd6 ? 2'(k - 4'd3) : 2'(k - 4'd6);
  endfunction
endpackage

// File: rtl/gaussian_win_addr.sv
// gaussian_win_addr: row/col/rowbase walker producing the source address of window
// element k and the first address of the following window, using adders only.
module gaussian_win_addr
  import gaussian_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              step,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);
  logic [DIM_W-1:0]  row, col;
  logic [ADDR_W-1:0] rb_up, rb, rb_dn, w, row_base;
  logic              col_end;
  assign w         = ADDR_W'(img_w);
  assign col_end   = col == img_w - DIM_W'(2);
  assign last      = col_end && row == img_h - DIM_W'(2);
  assign row_base  = win_row(k) == 2'd0 ? rb_up : win_row(k) == 2'd1 ? rb : rb_dn;
  assign addr      = row_base + ADDR_W'(col) + ADDR_W'(win_col(k)) - ADDR_W'(1);
  // first element of the next window: top-left pixel after the column/row advance
  assign next_addr = col_end ? rb : rb_up + ADDR_W'(col);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      row   <= '0;
      col   <= '0;
      rb_up <= '0;
      rb    <= '0;
      rb_dn <= '0;
    end else if (init) begin
      row   <= DIM_W'(1);
      col   <= DIM_W'(1);
      rb_up <= src_base;
      rb    <= src_base + w;
      rb_dn <= src_base + w + w;
    end else if (step) begin
      if (col_end) begin
        col   <= DIM_W'(1);
        row   <= row + DIM_W'(1);
        rb_up <= rb;
        rb    <= rb_dn;
        rb_dn <= rb_dn + w;
      end else begin
        col <= col + DIM_W'(1);
      end
    end
endmodule

// File: rtl/gaussian_window_seq.sv
// gaussian_window_seq: bus master walking every interior pixel of an image, loading
// each 3x3 window into the Gaussian accelerator and storing results compactly.
module gaussian_window_seq
  import gaussian_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [31:0]       src_rddata,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_wr,
  output logic [31:0]       dst_wrdata,
  output logic [3:0]        acc_addr,
  output logic              acc_wr_en,
  output logic              acc_rd_en,
  output logic [31:0]       acc_writedata,
  input  logic [31:0]       acc_readdata
);
  state_t            state;
  logic [3:0]        k;
  logic [DIM_W-1:0]  w_r, h_r;
  logic [ADDR_W-1:0] src_r, dst_r, n, win_addr, first_addr;
  logic              last;
  gaussian_win_addr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_win_addr (
    .clk      (clk),
    .reset_n  (reset_n),
    .init     (state == CHECK),
    .step     (state == STORE),
    .img_w    (w_r),
    .img_h    (h_r),
    .src_base (src_r),
    .k        (k + 4'd1),
    .addr     (win_addr),
    .next_addr(first_addr),
    .last     (last)
  );
  // read data lands one cycle after its strobe, so it is forwarded straight through
  assign acc_writedata = acc_wr_en ? src_rddata : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      k          <= '0;
      n          <= '0;
      w_r        <= '0;
      h_r        <= '0;
      src_r      <= '0;
      dst_r      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      src_addr   <= '0;
      src_rd     <= 1'b0;
      dst_addr   <= '0;
      dst_wr     <= 1'b0;
      dst_wrdata <= '0;
      acc_addr   <= '0;
      acc_wr_en  <= 1'b0;
      acc_rd_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          w_r   <= img_w;
          h_r   <= img_h;
          src_r <= src_base;
          dst_r <= dst_base;
          err   <= 1'b0;
          busy  <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (w_r < DIM_W'(3) || h_r < DIM_W'(3)) begin
          err   <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end else begin
          n        <= '0;
          k        <= '0;
          src_rd   <= 1'b1;
          src_addr <= src_r;
          state    <= FETCH;
        end
        FETCH: if (k == FETCH_LEN - 4'd1) begin
          acc_wr_en <= 1'b0;
          acc_rd_en <= 1'b1;
          acc_addr  <= ACC_RESULT;
          state     <= CONV;
        end else begin
          k         <= k + 4'd1;
          src_rd    <= k < 4'd8;
          src_addr  <= win_addr;
          acc_wr_en <= 1'b1;
          acc_addr  <= ACC_IMG00 + k;
        end
        CONV: begin
          acc_rd_en  <= 1'b0;
          dst_wrdata <= acc_readdata;
          dst_wr     <= 1'b1;
          dst_addr   <= dst_r + n;
          state      <= STORE;
        end
        STORE: begin
          dst_wr <= 1'b0;
          n      <= n + ADDR_W'(1);
          if (last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            k        <= '0;
            src_rd   <= 1'b1;
            src_addr <= first_addr;
            state    <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gaussian_window_seq.sv
// tb_gaussian_window_seq: drives frames from a vector table against memory and
// accelerator models, scoreboarding every destination write and frame timing.
module tb_gaussian_window_seq;
  import gaussian_pkg::*;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 10;
  logic clk = 0, reset_n = 0, start = 0;
  logic [DIM_W-1:0] img_w = 0, img_h = 0;
  logic [ADDR_W-1:0] src_base = 0, dst_base = 0;
  logic busy, done, err, src_rd, dst_wr, acc_wr_en, acc_rd_en;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [31:0] src_rddata = 0, dst_wrdata, acc_writedata, acc_readdata;
  logic [3:0] acc_addr;
  logic [31:0] smem [0:4095];
  logic [31:0] acc_reg [0:9];
  logic [ADDR_W-1:0] src_hist [0:255];
  typedef struct {logic [ADDR_W-1:0] a; logic [31:0] d;} wr_t;
  typedef struct {string nm; int w; int h; logic [15:0] sa; logic [15:0] da; int pat; int rp;} vec_t;
  wr_t sbq[$];
  wr_t got[$];
  vec_t vec [0:5];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int n_src = 0, n_acc = 0, acc_k = 0, acc_bad = 0, viol = 0, frame_s0 = 0;

  gaussian_window_seq #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .img_w(img_w), .img_h(img_h),
    .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done), .err(err),
    .src_addr(src_addr), .src_rd(src_rd), .src_rddata(src_rddata),
    .dst_addr(dst_addr), .dst_wr(dst_wr), .dst_wrdata(dst_wrdata),
    .acc_addr(acc_addr), .acc_wr_en(acc_wr_en), .acc_rd_en(acc_rd_en),
    .acc_writedata(acc_writedata), .acc_readdata(acc_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (src_rd) src_rddata <= smem[src_addr[11:0]];
  always @(posedge clk) if (acc_wr_en && acc_addr >= 4'd1 && acc_addr <= 4'd9) acc_reg[acc_addr] <= acc_writedata;
  assign acc_readdata = (acc_reg[1] + 32'd2*acc_reg[2] + acc_reg[3] + 32'd2*acc_reg[4] + 32'd4*acc_reg[5]
                       + 32'd2*acc_reg[6] + acc_reg[7] + 32'd2*acc_reg[8] + acc_reg[9]) >> 4;

  always @(negedge clk) begin
    if (!reset_n) acc_k = 0;
    else begin
      if (src_rd) begin src_hist[n_src % 256] = src_addr; n_src++; end
      if (acc_wr_en) begin
        if (acc_addr != 4'(acc_k + 1)) acc_bad++;
        acc_k = (acc_k + 1) % 9;
        n_acc++;
      end
      if (dst_wr) got.push_back('{dst_addr, dst_wrdata});
      if (((src_rd | acc_wr_en | dst_wr) & acc_rd_en) || (dst_wr & (src_rd | acc_wr_en))) viol++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic prep(input int w, input int h, input logic [15:0] sa, input logic [15:0] da, input int pat);
    int img [0:63];
    int n, s, i;
    logic [15:0] a;
    n = 0;
    for (int j = 0; j < w*h; j++) begin
      img[j] = pat == 0 ? 100 : pat == 1 ? j : int'($urandom_range(0, 255));
      a = sa + 16'(j);
      smem[a[11:0]] = img[j];
    end
    for (int r = 1; r < h-1; r++)
      for (int c = 1; c < w-1; c++) begin
        i = r*w + c;
        s = img[i-w-1] + 2*img[i-w] + img[i-w+1] + 2*img[i-1] + 4*img[i] + 2*img[i+1]
          + img[i+w-1] + 2*img[i+w] + img[i+w+1];
        sbq.push_back('{da + 16'(n), 32'(s >> 4)});
        n++;
      end
  endtask

  task automatic run_frame(input string nm, input int w, input int h, input logic [15:0] sa,
                           input logic [15:0] da, input int pat, input int rp);
    int t0, n, exp_done, a0, g0;
    wr_t e, g;
    n = (w < 3 || h < 3) ? 0 : (w-2)*(h-2);
    exp_done = 2 + PIX_CYCLES*n;
    prep(w, h, sa, da, pat);
    @(negedge clk);
    frame_s0 = n_src; a0 = n_acc; g0 = got.size();
    img_w = DIM_W'(w); img_h = DIM_W'(h); src_base = sa; dst_base = da;
    start = 1; t0 = cyc;
    @(negedge clk);
    start = 0;
    chk({nm, "_busy_check"}, 32'(busy), 32'd1);
    while (!done && cyc - t0 < exp_done + 20) begin
      @(negedge clk);
      start = rp != 0 && cyc - t0 == rp;
      if (start) img_w = DIM_W'(3);
    end
    start = 0;
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_done_cycle"}, 32'(cyc - t0), 32'(exp_done));
    chk({nm, "_err"}, 32'(err), 32'(n == 0));
    chk({nm, "_busy_done"}, 32'(busy), 32'd0);
    chk({nm, "_src_reads"}, 32'(n_src - frame_s0), 32'(9*n));
    chk({nm, "_acc_writes"}, 32'(n_acc - a0), 32'(9*n));
    chk({nm, "_dst_writes"}, 32'(got.size() - g0), 32'(n));
    chk({nm, "_acc_order"}, 32'(acc_bad), 32'd0);
    chk({nm, "_strobe_overlap"}, 32'(viol), 32'd0);
    for (int j = 0; j < n && g0 + j < got.size(); j++) begin
      e = sbq.pop_front();
      g = got[g0 + j];
      chk({nm, "_dst_addr"}, 32'(g.a), 32'(e.a));
      chk({nm, "_dst_data"}, g.d, e.d);
    end
    sbq.delete();
  endtask

  logic [15:0] exp_sa [0:8] = '{16'h100, 16'h101, 16'h102, 16'h104, 16'h105, 16'h106, 16'h108, 16'h109, 16'h10A};

  initial begin
    vec[0] = '{"v3x3_const", 3, 3, 16'h0000, 16'h0800, 0, 0};
    vec[1] = '{"v4x3_index", 4, 3, 16'h0100, 16'h0900, 1, 0};
    vec[2] = '{"v2x5_err",   2, 5, 16'h0200, 16'h0A00, 2, 0};
    vec[3] = '{"v5x5_repulse", 5, 5, 16'h0300, 16'h0B00, 2, 30};
    vec[4] = '{"v3x3_wrap",  3, 3, 16'hFFFE, 16'hFFFF, 2, 0};
    vec[5] = '{"v6x4_rand",  6, 4, 16'h0400, 16'h0C00, 2, 0};
    for (int i = 0; i < 4096; i++) smem[i] = 0;
    for (int i = 0; i < 10; i++) acc_reg[i] = 0;
    repeat (2) @(negedge clk);
    chk("reset_flags", 32'({busy, done, err}), 32'd0);
    chk("reset_strobes", 32'({src_rd, acc_wr_en, acc_rd_en, dst_wr}), 32'd0);
    chk("reset_addrs", 32'({src_addr, dst_addr}), 32'd0);
    reset_n = 1;
    for (int i = 0; i < 6; i++) run_frame(vec[i].nm, vec[i].w, vec[i].h, vec[i].sa, vec[i].da, vec[i].pat, vec[i].rp);
    run_frame("h4x3_addr", 4, 3, 16'h0100, 16'h0D00, 1, 0);
    for (int j = 0; j < 9; j++) chk("h4x3_src_addr", 32'(src_hist[(frame_s0 + j) % 256]), 32'(exp_sa[j]));
    run_frame("h_err_hold", 1, 3, 16'h0000, 16'h0000, 0, 0);
    repeat (3) @(negedge clk);
    chk("err_hold", 32'({err, busy, done}), 32'b100);
    prep(5, 5, 16'h0200, 16'h0040, 2);
    @(negedge clk);
    img_w = 5; img_h = 5; src_base = 16'h0200; dst_base = 16'h0040; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("pre_reset_fetch", 32'({busy, src_rd}), 32'b11);
    reset_n = 0;
    #1;
    chk("midrst_flags", 32'({busy, done, err}), 32'd0);
    chk("midrst_strobes", 32'({src_rd, acc_wr_en, acc_rd_en, dst_wr}), 32'd0);
    chk("midrst_acc_wdata", acc_writedata, 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    run_frame("after_reset", 5, 5, 16'h0200, 16'h0040, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gaussian_window_seq.md
Name: gaussian_window_seq

Overview:
- Bus-master sequencer that drives the 3x3 Gaussian convolution accelerator.
- Walks every interior pixel of a W x H image held in a source memory. For each pixel it loads the 9-pixel window into accelerator registers 1..9, reads the convolved result from register 0, and stores it compactly to a destination memory.
- Sits between the HPS-configured control registers and the accelerator's slave port.

Parameters:
- ADDR_W, 16, source and destination word-address width.
- DIM_W, 10, width of the image width/height fields.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a frame (sampled only in IDLE)
- img_w  in  DIM_W  image width in pixels
- img_h  in  DIM_W  image height in pixels
- src_base  in  ADDR_W  word address of pixel (0,0)
- dst_base  in  ADDR_W  word address of first result
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of frame
- err  out  1  valid with done; 1 = dimensions < 3, nothing processed
- src_addr  out  ADDR_W  source read address
- src_rd  out  1  source read strobe; data returned 1 cycle later
- src_rddata  in  32  source read data
- dst_addr  out  ADDR_W  destination write address
- dst_wr  out  1  destination write strobe
- dst_wrdata  out  32  destination write data
- acc_addr  out  4  accelerator register address
- acc_wr_en  out  1  accelerator write enable
- acc_rd_en  out  1  accelerator read enable
- acc_writedata  out  32  accelerator write data
- acc_readdata  in  32  accelerator read data (combinational, same cycle)

Behaviour:
- Reset: asynchronous, active-low. All outputs 0; FSM to IDLE; row/col/output counters cleared. Reset mid-frame aborts immediately; no further bus strobes are issued.
- States: IDLE, CHECK, FETCH, CONV, STORE, DONE.
- IDLE:
  - start=1 latches img_w, img_h, src_base, dst_base, then goes to CHECK.
  - start while not IDLE is ignored.
- CHECK (1 cycle):
  - If img_w<3 or img_h<3: go to DONE with err=1.
  - Else: row=1, col=1, n=0, rowbase=src_base+img_w; go to FETCH.
- FETCH (10 cycles, k=0..9):
  - Cycles k=0..8 assert src_rd with src_addr = rowbase + (dr-1)*img_w + col + (dc-1), where dr=k/3 and dc=k%3 (row-major window order).
  - Cycles k=1..9 assert acc_wr_en with acc_addr=k and acc_writedata=src_rddata, i.e. the read issued at k-1.
  - Reads and writes overlap.
  - Address arithmetic uses adders only; no multiplier. Keep rowbase-img_w, rowbase, rowbase+img_w as running registers.
- CONV (1 cycle): acc_rd_en=1, acc_addr=0; register acc_readdata into the result register.
- STORE (1 cycle): dst_wr=1, dst_addr=dst_base+n, dst_wrdata=result; then advance:
  - n++.
  - If col==img_w-2: col=1, row++, rowbase+=img_w; else col++.
  - If the old row==img_h-2 and old col==img_w-2: go to DONE; else go to FETCH.
- DONE (1 cycle): done=1, busy=0; err held until the next start. Then go to IDLE.
- Strobe hygiene: acc_wr_en, acc_rd_en, src_rd and dst_wr are never high in the same cycle except src_rd with acc_wr_en during FETCH. All are 0 outside FETCH/CONV/STORE.
- Timing: 12 cycles per output. With start in cycle 0, CHECK is cycle 1 and done pulses in cycle 12*N+2, where N=(img_w-2)*(img_h-2).
- Address overflow wraps modulo 2^ADDR_W; no error is flagged.
- Pixel data passes through unmodified. Software keeps pixels ≤ 8 bits so the accelerator's 32-bit products do not overflow.

Decomposition:
- Package gaussian_pkg:
  - Accelerator register map constants: ACC_RESULT=0, ACC_IMG00=1 .. ACC_IMG22=9.
  - FSM state enum.
  - Per-window cycle constants: FETCH_LEN=10, PIX_CYCLES=12.
- One sub-module, gaussian_win_addr: holds the row/col/rowbase counters and produces the window read address for index k. The top level holds the FSM and bus muxing.

Test Plan:
- 3x3 image, all pixels 100, paired with the accelerator model -> one dst write of 100 at dst_base; done in cycle 14; err=0; exactly 9 src reads and 9 acc writes at addresses 1..9.
- 4x3 image, pixel value = index 0..11, src_base=0x100 -> windows centred at (1,1) and (1,2); src_addr sequence for the first window is 0x100,0x101,0x102,0x104,0x105,0x106,0x108,0x109,0x10A; 2 dst writes at dst_base, dst_base+1; done in cycle 26.
- img_w=2, img_h=5 -> done with err=1 in cycle 2; no src_rd, acc_wr_en or dst_wr ever asserted.
- 5x5 frame with start re-pulsed mid-frame -> ignored; exactly 9 outputs; done in cycle 110.
- Assert reset_n low during FETCH of a 5x5 frame -> all outputs 0 immediately; a new start then processes a full frame correctly from (1,1).
- Back-to-back frames: start pulsed in the cycle after done -> second frame runs fully; err cleared.
